regfile_wb_ctrl: RTL



---
 rtl/regfile_wb_ctrl_pkg.sv | 19 +
 rtl/wb_fifo.sv | 77 +++++++
 rtl/regfile_wb_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/regfile_wb_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_ctrl_pkg
// Shared definitions for the register-file writeback controller: architectural
// sizes and the load-response queue entry.
// No ports (package).
// -----------------------------------------------------------------------------
package regfile_wb_ctrl_pkg;

  localparam int REG_W = 5;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  // One buffered load response: destination register and returned data.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } lq_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Small synchronous FIFO holding load responses until they win the register
// file write port. The head entry is visible combinationally so the arbiter
// can write it in the same cycle it pops it.
// Ports:
//   clk, rst        clock and synchronous active-high reset (empties the FIFO)
//   push, push_data enqueue request and entry (ignored when full)
//   pop             dequeue request (ignored when empty)
//   head            current oldest entry (undefined when empty)
//   full, empty     occupancy flags
//   count           number of valid entries
// -----------------------------------------------------------------------------
module wb_fifo
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  lq_entry_t                    push_data,
  input  logic                         pop,
  output lq_entry_t                    head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  lq_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            push_ok;
  logic            pop_ok;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    full    = (cnt == CW'(DEPTH));
    empty   = (cnt == '0);
    push_ok = push & ~full;
    pop_ok  = pop & ~empty;
    head    = mem[rd_ptr];
    count   = cnt;
  end

  // Storage needs no reset; validity is tracked entirely by cnt.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_wb_ctrl
// Writeback controller and load scoreboard for the 32x32 register file.
// Shares the single write port between the ALU writeback and buffered load
// responses, tracks registers with pending load writes, and stalls issue on
// RAW/WAW hazards or when too many loads are outstanding.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   iss_valid/rs1/rs2/rd/is_load      instruction presented at issue
//   iss_stall                         hold issue this cycle
//   alu_wb_valid/rd/data, alu_wb_ready  ALU writeback request / acceptance
//   ld_resp_valid/rd/data, ld_resp_ready  returning load data / queue space
//   rf_we, rf_rd, rf_wd               register file write port
//   busy_mask                         pending-load bit per register (bit 0 = 0)
//   ld_outstanding                    issued but not yet retired loads
// -----------------------------------------------------------------------------
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int LQ_DEPTH        = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 iss_valid,
  input  logic [REG_W-1:0]                     iss_rs1,
  input  logic [REG_W-1:0]                     iss_rs2,
  input  logic [REG_W-1:0]                     iss_rd,
  input  logic                                 iss_is_load,
  output logic                                 iss_stall,
  input  logic                                 alu_wb_valid,
  output logic                                 alu_wb_ready,
  input  logic [REG_W-1:0]                     alu_wb_rd,
  input  logic [XLEN-1:0]                      alu_wb_data,
  input  logic                                 ld_resp_valid,
  output logic                                 ld_resp_ready,
  input  logic [REG_W-1:0]                     ld_resp_rd,
  input  logic [XLEN-1:0]                      ld_resp_data,
  output logic                                 rf_we,
  output logic [REG_W-1:0]                     rf_rd,
  output logic [XLEN-1:0]                      rf_wd,
  output logic [NREGS-1:0]                     busy_mask,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] ld_outstanding
);

  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  localparam int SW = $clog2(STARVE_LIMIT+1);
  localparam int CW = $clog2(LQ_DEPTH+1);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_n;
  logic [OW-1:0]    out_q;
  logic [SW-1:0]    starve_q;

  lq_entry_t        head;
  lq_entry_t        push_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  logic             hz;
  logic             at_limit;
  logic             load_fire;
  logic             load_win;
  logic             resp_push;

  assign push_entry = '{rd: ld_resp_rd, data: ld_resp_data};

  wb_fifo #(
    .DEPTH(LQ_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (resp_push),
    .push_data (push_entry),
    .pop       (load_win),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Hazard detection, write-port arbitration and handshakes. Everything is
  // forced to its idle value while rst is high so no write or stall escapes
  // during the reset cycle.
  always_comb begin
    hz            = busy_q[iss_rs1] | busy_q[iss_rs2] | busy_q[iss_rd];
    at_limit      = (out_q == OW'(MAX_OUTSTANDING));
    iss_stall     = ~rst & iss_valid & (hz | (iss_is_load & at_limit));
    load_fire     = ~rst & iss_valid & ~iss_stall & iss_is_load;
    load_win      = ~rst & ~fifo_empty &
                    (~alu_wb_valid | (starve_q == SW'(STARVE_LIMIT)));
    ld_resp_ready = rst | ~fifo_full;
    resp_push     = ~rst & ld_resp_valid & ~fifo_full;
    alu_wb_ready  = ~load_win;

    rf_we = 1'b0;
    rf_rd = '0;
    rf_wd = '0;
    if (load_win) begin
      rf_we = (head.rd != '0);
      rf_rd = head.rd;
      rf_wd = head.data;
    end else if (alu_wb_valid & ~rst) begin
      rf_we = (alu_wb_rd != '0);
      rf_rd = alu_wb_rd;
      rf_wd = alu_wb_data;
    end

    // Clear for the retiring load first so a same-edge set takes priority.
    busy_n = busy_q;
    if (load_win) begin
      busy_n[head.rd] = 1'b0;
    end
    if (load_fire && iss_rd != '0) begin
      busy_n[iss_rd] = 1'b1;
    end
    busy_n[0] = 1'b0;

    busy_mask      = busy_q;
    ld_outstanding = out_q;
  end

  // Scoreboard, outstanding-load counter and starvation counter. The starve
  // counter only runs while a queued response is being passed over.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      out_q    <= '0;
      starve_q <= '0;
    end else begin
      busy_q <= busy_n;
      case ({load_fire, load_win})
        2'b10:   out_q <= out_q + 1'b1;
        2'b01:   out_q <= out_q - 1'b1;
        default: out_q <= out_q;
      endcase
      if (load_win || fifo_empty) begin
        starve_q <= '0;
      end else if (alu_wb_valid && starve_q != SW'(STARVE_LIMIT)) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

  // Protocol checks on the surrounding pipeline.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(alu_wb_valid && alu_wb_ready && busy_q[alu_wb_rd]));
      assert (!ld_resp_valid || (int'(out_q) > int'(fifo_count)));
      assert (!(load_fire && !load_win && out_q == OW'(MAX_OUTSTANDING)));
      assert (!(load_win && !load_fire && out_q == '0));
    end
  end

endmodule
